// File: rtl/if_pkg.sv
// Shared types and widths for the instruction-fetch front end.
package if_pkg;
  localparam int PC_W       = 64;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Fetch buffer: small synchronous FIFO of {pc, inst} with flush; head reads 0 when empty.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [AW:0]  count,
  output fetch_entry_t head
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset: head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, 1-cycle imem requests, fetch buffer, redirect flush.
// Optional FETCH_ALIGN_CHK_EN adds a sticky fetch_misalign flag for unaligned redirect targets.
module if_fetch_unit #(
  parameter int              PC_W      = if_pkg::PC_W,
  parameter int              INST_W    = if_pkg::INST_W,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_inst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              stall,
  output logic              fetch_valid,
  output logic [PC_W-1:0]   PC_Out,
  output logic [INST_W-1:0] Inst_output
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic              fetch_misalign
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [CW-1:0]        count;
  logic [CW:0]          credit;
  logic                 inflight, issue, push, pop, hold;
  logic [PC_W-1:0]      fetch_pc, infl_pc;
  if_pkg::fetch_entry_t din, head;

  assign fetch_valid = (count != '0) & ~redirect_valid;
  assign pop         = fetch_valid & ~stall;
  assign push        = imem_rsp_valid & inflight & ~redirect_valid;

  // Slots already owed (buffered + in flight) minus the one leaving this cycle.
  assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue  = reset & ~redirect_valid & ~hold & (credit < (CW+1)'(BUF_DEPTH));

  assign imem_req_valid = issue;
  assign imem_req_addr  = fetch_pc;
  assign din            = '{pc: infl_pc, inst: imem_rsp_inst};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      infl_pc  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + PC_W'(if_pkg::INST_BYTES);
        infl_pc  <= fetch_pc;
      end
      if (redirect_valid) fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic [PC_W-1:0] mis_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_misalign <= 1'b0;
      mis_pc         <= '0;
    end else if (redirect_valid) begin
      fetch_misalign <= |redirect_pc[1:0];
      mis_pc         <= redirect_pc;
    end
  end

  assign hold   = fetch_misalign;
  assign PC_Out = fetch_misalign ? mis_pc : head.pc;
`else
  assign hold   = 1'b0;
  assign PC_Out = head.pc;
`endif
  assign Inst_output = head.inst;

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected fetch PCs queued per stream, checked on each pop.
module tb_if_fetch_unit;
  logic        clk = 1'b0, reset = 1'b0;
  logic        imem_req_valid, imem_rsp_valid = 1'b0;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_rsp_inst = '0;
  logic        redirect_valid = 1'b0, stall = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fetch_valid;
  logic [63:0] PC_Out;
  logic [31:0] Inst_output;
`ifdef FETCH_ALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  int checks = 0, failures = 0;
  logic [63:0] exp_q [$];
  logic [63:0] e;
  logic        mon_en = 1'b0, stale_inj = 1'b0;

  if_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_inst(imem_rsp_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .fetch_valid(fetch_valid),
    .PC_Out(PC_Out), .Inst_output(Inst_output)
`ifdef FETCH_ALIGN_CHK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hA5A5_5A5A;
  endfunction

  // 1-cycle instruction memory; stale_inj forces a bogus response.
  always @(posedge clk) begin
    imem_rsp_valid <= (reset & imem_req_valid) | stale_inj;
    imem_rsp_inst  <= stale_inj ? 32'hDEAD_BEEF : inst_of(imem_req_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [63:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
  endtask

  task automatic cyc(input logic st, input logic rv, input logic [63:0] rp);
    @(posedge clk); #1;
    stall = st; redirect_valid = rv; redirect_pc = rp;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && reset && fetch_valid && !stall) begin
      chk("sb_avail", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", PC_Out, e);
        chk("sb_inst", 64'(Inst_output), 64'(inst_of(e)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_fv", fetch_valid, 0);
    chk("rst_req", imem_req_valid, 0);
    chk("rst_pc", PC_Out, 0);
    chk("rst_inst", Inst_output, 0);

    // Reset release and first fetches
    push_seq(64'h0, 64);
    mon_en = 1'b1;
    @(posedge clk); #1 reset = 1'b1; #1;
    chk("c0_req", imem_req_valid, 1);
    chk("c0_addr", imem_req_addr, 64'h0);
    chk("c0_fv", fetch_valid, 0);
    cyc(0, 0, 0);
    chk("c1_fv", fetch_valid, 0);
    chk("c1_addr", imem_req_addr, 64'h4);
    cyc(0, 0, 0);
    chk("c2_fv", fetch_valid, 1);
    chk("c2_pc", PC_Out, 64'h0);

    // Stall cycles 3-8: buffer fills, requests stop, head frozen
    for (int c = 3; c <= 8; c++) begin
      cyc(1, 0, 0);
      if (c == 3) chk("stall_pc3", PC_Out, 64'h4);
      if (c >= 4) chk("stall_req_off", imem_req_valid, 0);
      if (c == 8) begin
        chk("stall_fv8", fetch_valid, 1);
        chk("stall_pc8", PC_Out, 64'h4);
      end
    end
    for (int c = 9; c <= 12; c++) begin
      cyc(0, 0, 0);
      chk("no_gap_fv", fetch_valid, 1);
    end

    // Redirect with buffer non-empty and a request in flight
    cyc(0, 1, 64'h100);
    chk("rd_t_fv", fetch_valid, 0);
    chk("rd_t_req", imem_req_valid, 0);
    push_seq(64'h100, 64);
    cyc(0, 0, 0);
    chk("rd_t1_fv", fetch_valid, 0);
    chk("rd_t1_req", imem_req_valid, 1);
    chk("rd_t1_addr", imem_req_addr, 64'h100);
    cyc(0, 0, 0);
    chk("rd_t2_fv", fetch_valid, 0);
    cyc(0, 0, 0);
    chk("rd_t3_fv", fetch_valid, 1);
    chk("rd_t3_pc", PC_Out, 64'h100);
    cyc(0, 0, 0);
    chk("rd_t4_pc", PC_Out, 64'h104);

    // Redirect while stalled with a full buffer
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    chk("full_req_off", imem_req_valid, 0);
    cyc(1, 1, 64'h300);
    chk("rs_t_fv", fetch_valid, 0);
    push_seq(64'h300, 64);
    cyc(1, 0, 0);
    chk("rs_t1_fv", fetch_valid, 0);
    chk("rs_t1_addr", imem_req_addr, 64'h300);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rs_t3_pc", PC_Out, 64'h300);
    cyc(1, 0, 0);
    chk("rs_t4_req", imem_req_valid, 0);
    chk("rs_t4_pc", PC_Out, 64'h300);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);

    // Reset mid-stream, stale response right after release
    @(posedge clk); #1 reset = 1'b0; #1;
    chk("mr_fv", fetch_valid, 0);
    chk("mr_pc", PC_Out, 0);
    chk("mr_inst", Inst_output, 0);
    chk("mr_req", imem_req_valid, 0);
    push_seq(64'h0, 64);
    @(posedge clk); #1 stale_inj = 1'b1;
    @(posedge clk); #1 reset = 1'b1; stale_inj = 1'b0; #1;
    chk("mr_c0_addr", imem_req_addr, 64'h0);
    cyc(0, 0, 0);
    chk("mr_c1_fv", fetch_valid, 0);
    cyc(0, 0, 0);
    chk("mr_c2_fv", fetch_valid, 1);
    chk("mr_c2_pc", PC_Out, 64'h0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);

`ifdef FETCH_ALIGN_CHK_EN
    cyc(0, 1, 64'h102);
    exp_q.delete();
    cyc(0, 0, 0);
    chk("ma_flag", fetch_misalign, 1);
    chk("ma_fv", fetch_valid, 0);
    chk("ma_pc", PC_Out, 64'h102);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0);
      chk("ma_req_off", imem_req_valid, 0);
    end
    cyc(0, 1, 64'h200);
    push_seq(64'h200, 64);
    cyc(0, 0, 0);
    chk("ma_clear", fetch_misalign, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("ma_t3_fv", fetch_valid, 1);
    chk("ma_t3_pc", PC_Out, 64'h200);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
